// File: rtl/boid_speed_limit.sv
// Boid speed limiter: clamps velocity magnitude into [MIN_SPEED, MAX_SPEED]
// using an alpha-max-beta-min estimate and a restoring divider, then integrates position.
module boid_speed_limit #(
  parameter logic [31:0] MAX_SPEED = 32'h0006_0000,
  parameter logic [31:0] MIN_SPEED = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] vx_in,
  input  logic [31:0] vy_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] vx_out,
  output logic [31:0] vy_out
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SPEED  = 3'd1;
  localparam logic [2:0] DIV    = 3'd2;
  localparam logic [2:0] SCALE  = 3'd3;
  localparam logic [2:0] UPDATE = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [5:0] DIV_LAST = 6'd47;

  // Magnitude of a signed 16.16 value; the most negative code has no positive twin.
  function automatic logic [31:0] abs_sat(input logic [31:0] v);
    logic [31:0] a;
    if (v == 32'h8000_0000) a = 32'h7FFF_FFFF;
    else if (v[31])         a = 32'd0 - v;
    else                    a = v;
    return a;
  endfunction

  function automatic logic [31:0] sat_quot(input logic [47:0] q);
    logic [31:0] s;
    if (q[47:31] != 17'd0) s = 32'h7FFF_FFFF;
    else                   s = q[31:0];
    return s;
  endfunction

  // Signed 16.16 times unsigned ratio, arithmetic shift keeps floor rounding.
  function automatic logic [31:0] scale_v(input logic [31:0] v, input logic [31:0] r);
    logic [63:0] p;
    p = $signed({{32{v[31]}}, v}) * $signed({32'd0, r});
    return p[47:16];
  endfunction

  logic [2:0]  state_r, state_next_s;
  logic        in_ready_r, out_valid_r;
  logic [31:0] x_r, y_r, vx_r, vy_r;
  logic [31:0] speed_r, r_r;
  logic [5:0]  div_cnt_r;
  logic [47:0] quo_r;
  logic [31:0] rem_r;

  logic        accept_s;
  logic [31:0] abs_x_s, abs_y_s, speed_s, limit_s;
  logic        too_fast_s, too_slow_s;
  logic [32:0] rem_shift_s;
  logic [31:0] rem_next_s;
  logic [47:0] quo_next_s;

  assign accept_s = in_valid & in_ready_r;

  // Speed estimate and limit selection from the captured velocity.
  always_comb begin
    abs_x_s = abs_sat(vx_r);
    abs_y_s = abs_sat(vy_r);
    if (abs_x_s >= abs_y_s) speed_s = abs_x_s + (abs_y_s >> 1);
    else                    speed_s = abs_y_s + (abs_x_s >> 1);
    too_fast_s = (speed_s > MAX_SPEED);
    too_slow_s = (speed_s != 32'd0) && (speed_s < MIN_SPEED);
    if (too_fast_s) limit_s = MAX_SPEED;
    else            limit_s = MIN_SPEED;
  end

  // One restoring-division step; the remainder always stays below the divisor.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[47]};
    if (rem_shift_s >= {1'b0, speed_r}) begin
      rem_next_s = rem_shift_s[31:0] - speed_r;
      quo_next_s = {quo_r[46:0], 1'b1};
    end else begin
      rem_next_s = rem_shift_s[31:0];
      quo_next_s = {quo_r[46:0], 1'b0};
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = SPEED;
        else          state_next_s = IDLE;
      end
      SPEED: begin
        if (too_fast_s || too_slow_s) state_next_s = DIV;
        else                          state_next_s = UPDATE;
      end
      DIV: begin
        if (div_cnt_r == DIV_LAST) state_next_s = SCALE;
        else                       state_next_s = DIV;
      end
      SCALE:  state_next_s = UPDATE;
      UPDATE: state_next_s = DONE;
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State and handshake flags; in_ready returns one cycle after re-entering IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s)                           in_ready_r <= 1'b0;
      else if (state_r == IDLE && !in_ready_r) in_ready_r <= 1'b1;
      else                                    in_ready_r <= in_ready_r;
      if (state_r == UPDATE)                 out_valid_r <= 1'b1;
      else if (state_r == DONE && out_ready) out_valid_r <= 1'b0;
      else                                   out_valid_r <= out_valid_r;
    end
  end

  // Captured boid state; velocity is rewritten by the scale step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r  <= 32'd0;
      y_r  <= 32'd0;
      vx_r <= 32'd0;
      vy_r <= 32'd0;
    end else if (accept_s) begin
      x_r  <= x_in;
      y_r  <= y_in;
      vx_r <= vx_in;
      vy_r <= vy_in;
    end else if (state_r == SCALE) begin
      vx_r <= scale_v(vx_r, r_r);
      vy_r <= scale_v(vy_r, r_r);
    end else begin
      vx_r <= vx_r;
      vy_r <= vy_r;
    end
  end

  // Speed register and the 48-step divider producing the scale ratio.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_r   <= 32'd0;
      r_r       <= 32'd0;
      div_cnt_r <= 6'd0;
      quo_r     <= 48'd0;
      rem_r     <= 32'd0;
    end else if (state_r == SPEED) begin
      speed_r   <= speed_s;
      div_cnt_r <= 6'd0;
      quo_r     <= {limit_s, 16'd0};
      rem_r     <= 32'd0;
    end else if (state_r == DIV) begin
      div_cnt_r <= div_cnt_r + 6'd1;
      quo_r     <= quo_next_s;
      rem_r     <= rem_next_s;
      if (div_cnt_r == DIV_LAST) r_r <= sat_quot(quo_next_s);
      else                       r_r <= r_r;
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  // Result registers, held stable through DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out  <= 32'd0;
      y_out  <= 32'd0;
      vx_out <= 32'd0;
      vy_out <= 32'd0;
    end else if (state_r == UPDATE) begin
      x_out  <= x_r + vx_r;
      y_out  <= y_r + vy_r;
      vx_out <= vx_r;
      vy_out <= vy_r;
    end else begin
      x_out  <= x_out;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_boid_speed_limit.sv
// Directed + random bench for boid_speed_limit with a queue scoreboard of expected results.
module tb_boid_speed_limit;

  localparam longint MAXS = 64'h0006_0000;
  localparam longint MINS = 64'h0003_0000;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] vx;
    logic [31:0] vy;
    logic [7:0]  lat;
  } exp_t;

  logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x_in, y_in, vx_in, vy_in, x_out, y_out, vx_out, vy_out;

  int   compared;
  int   mismatched;
  exp_t sb[$];

  boid_speed_limit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .vx_in(vx_in), .vy_in(vy_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .vx_out(vx_out), .vy_out(vy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint mag(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    if (s == -64'sd2147483648) return 64'sd2147483647;
    return (s < 0) ? -s : s;
  endfunction

  // Reference model in plain 64-bit integer arithmetic.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] vx, input logic [31:0] vy);
    exp_t e;
    longint ax, ay, spd, lim, r, nvx, nvy;
    logic [63:0] t;
    bit dv;
    ax = mag(vx);
    ay = mag(vy);
    spd = (ax > ay) ? ax + ay / 2 : ay + ax / 2;
    nvx = longint'($signed(vx));
    nvy = longint'($signed(vy));
    dv = 1'b0;
    lim = 0;
    if (spd > MAXS) begin lim = MAXS; dv = 1'b1; end
    else if (spd > 0 && spd < MINS) begin lim = MINS; dv = 1'b1; end
    if (dv) begin
      r = (lim * 65536) / spd;
      if (r > 64'sh7FFF_FFFF) r = 64'sh7FFF_FFFF;
      nvx = (nvx * r) >>> 16;
      nvy = (nvy * r) >>> 16;
    end
    t = nvx; e.vx = t[31:0];
    t = nvy; e.vy = t[31:0];
    e.x = x + e.vx;
    e.y = y + e.vy;
    e.lat = dv ? 8'd51 : 8'd2;
    return e;
  endfunction

  // One full transaction: send, measure latency, compare, optional backpressure, handshake.
  task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic [31:0] vx,
                         input logic [31:0] vy, input exp_t e, input int hold);
    int n;
    exp_t got;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    x_in = x; y_in = y; vx_in = vx; vy_in = vy; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("latency", 32'(n), 32'(e.lat));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("x_out", x_out, got.x);
      check("y_out", y_out, got.y);
      check("vx_out", vx_out, got.vx);
      check("vy_out", vy_out, got.vy);
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; x_in = 32'hDEAD_0000; vx_in = 32'h0000_0001;
        @(posedge clk); #1;
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_x_stable", x_out, got.x);
        check("bp_vx_stable", vx_out, got.vx);
      end
    end else begin
      check("sb_nonempty", 32'd0, 32'd1);
    end
    out_ready = 1'b1; in_valid = 1'b1; x_in = 32'hBEEF_0000; vx_in = 32'h0000_0001;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drop_out_valid", {31'd0, out_valid}, 32'd0);
    check("drop_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rise_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] vx,
                              input logic [31:0] vy, input logic [7:0] lat);
    exp_t e;
    e.x = x; e.y = y; e.vx = vx; e.vy = vy; e.lat = lat;
    return e;
  endfunction

  initial begin
    logic [31:0] p150, rx, ry;
    int n;
    compared = 0; mismatched = 0;
    p150 = 32'd150 << 16;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_in = 32'd0; y_in = 32'd0; vx_in = 32'd0; vy_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_x_out", x_out, 32'd0);
    check("rst_vy_out", vy_out, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Specification scenarios with hand-derived constants.
    run_txn(p150, p150, 32'd3 << 16, 32'd0, mk(32'd153 << 16, p150, 32'd3 << 16, 32'd0, 8'd2), 0);
    run_txn(p150, p150, 32'd8 << 16, 32'd0, mk(32'd156 << 16, p150, 32'd6 << 16, 32'd0, 8'd51), 0);
    run_txn(p150, p150, 32'd0, 32'hFFFE_0000, mk(p150, 32'd147 << 16, 32'd0, 32'hFFFD_0000, 8'd51), 0);
    run_txn(p150, p150, 32'd0, 32'd0, mk(p150, p150, 32'd0, 32'd0, 8'd2), 0);
    run_txn(32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 32'h0004_0000,
            mk(32'h0002_0000, 32'h0006_0000, 32'h0001_0000, 32'h0004_0000, 8'd2), 5);

    // Boundaries: exact limits, just over, tiny speeds, most negative code, wrap.
    run_txn(p150, p150, 32'h0006_0000, 32'd0, model(p150, p150, 32'h0006_0000, 32'd0), 0);
    run_txn(p150, p150, 32'h0006_0001, 32'd0, model(p150, p150, 32'h0006_0001, 32'd0), 0);
    run_txn(p150, p150, 32'h0000_0001, 32'd0, mk(p150 + 32'h7FFF, p150, 32'h0000_7FFF, 32'd0, 8'd51), 0);
    run_txn(p150, p150, 32'hFFFF_FFFF, 32'd0, mk(p150 - 32'h8000, p150, 32'hFFFF_8000, 32'd0, 8'd51), 0);
    run_txn(p150, p150, 32'h8000_0000, 32'd0, mk(p150 - (32'd6 << 16), p150, 32'hFFFA_0000, 32'd0, 8'd51), 0);
    run_txn(32'hFFFF_0000, p150, 32'h0004_0000, 32'd0, mk(32'h0003_0000, p150, 32'h0004_0000, 32'd0, 8'd2), 0);
    run_txn(p150, p150, 32'h0005_0000, 32'hFFFB_0000, model(p150, p150, 32'h0005_0000, 32'hFFFB_0000), 0);

    // Random velocities in roughly +-10.0.
    for (int k = 0; k < 8; k++) begin
      rx = 32'($urandom_range(0, 32'h0014_0000)) - 32'h000A_0000;
      ry = 32'($urandom_range(0, 32'h0014_0000)) - 32'h000A_0000;
      run_txn(p150, p150, rx, ry, model(p150, p150, rx, ry), 0);
    end

    // Reset in the middle of a divide aborts silently.
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    x_in = p150; y_in = p150; vx_in = 32'd8 << 16; vy_in = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("middiv_busy", {31'd0, out_valid}, 32'd0);
    reset = 1'b1;
    #1;
    check("middiv_out_valid", {31'd0, out_valid}, 32'd0);
    check("middiv_x_out", x_out, 32'd0);
    check("middiv_y_out", y_out, 32'd0);
    check("middiv_vx_out", vx_out, 32'd0);
    check("middiv_vy_out", vy_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("middiv_in_ready", {31'd0, in_ready}, 32'd1);
    run_txn(p150, p150, 32'd3 << 16, 32'd0, mk(32'd153 << 16, p150, 32'd3 << 16, 32'd0, 8'd2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/boid_speed_limit.md
BOID_SPEED_LIMIT -- requirements
Module: boid_speed_limit

Interface
REQ-001 Parameter MAX_SPEED, default 32'h0006_0000, upper speed limit in unsigned 16.16 format (6.0).
REQ-002 Parameter MIN_SPEED, default 32'h0003_0000, lower speed limit in unsigned 16.16 format (3.0).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream (xy_writeback) holds a valid boid state.
REQ-006 in_ready  output  1  block can accept a boid this cycle.
REQ-007 x_in, y_in  input  32 each  position, unsigned 16.16.
REQ-008 vx_in, vy_in  input  32 each  rule-adjusted velocity (vx_bounded/vy_bounded), signed 16.16.
REQ-009 out_valid  output  1  result registers hold a valid boid state.
REQ-010 out_ready  input  1  downstream memory writeback accepts the result.
REQ-011 x_out, y_out  output  32 each  updated position, 16.16.
REQ-012 vx_out, vy_out  output  32 each  speed-limited velocity, signed 16.16.

Function
REQ-013 Block SHALL use FSM states IDLE, SPEED, DIV, SCALE, UPDATE, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 At handshake edge E (in_valid & in_ready), block SHALL register x_in, y_in, vx_in, vy_in and go to SPEED; inputs SHALL be ignored at all other times.
REQ-015 At SPEED, block SHALL register speed = max(|vx|,|vy|) + (min(|vx|,|vy|) >> 1), unsigned 32-bit; |32'h8000_0000| SHALL saturate to 32'h7FFF_FFFF.
REQ-016 SPEED SHALL go to DIV with limit L = MAX_SPEED if speed > MAX_SPEED, or L = MIN_SPEED if 0 < speed < MIN_SPEED; otherwise (speed == 0 or MIN_SPEED <= speed <= MAX_SPEED) it SHALL go to UPDATE with velocity unchanged.
REQ-017 DIV SHALL be a restoring divider computing r = ({L,16'b0}) / speed over exactly 48 cycles; a 48-bit quotient with bits [47:31] nonzero SHALL saturate r to 32'h7FFF_FFFF.
REQ-018 SCALE SHALL set v = (v * r) >>> 16 for both components using a 64-bit signed product truncated to 32 bits (rounding toward negative infinity).
REQ-019 UPDATE SHALL register x_out = x + vx, y_out = y + vy (32-bit modular add, no clamping), vx_out = vx, vy_out = vy, then go to DONE.
REQ-020 In DONE, out_valid SHALL be 1; outputs SHALL stay stable until out_valid & out_ready, then the FSM SHALL return to IDLE on that edge.
REQ-021 Latency from E to out_valid high SHALL be 2 cycles on the bypass path and 51 cycles on the divide path.
REQ-022 Throughput SHALL be one boid per transaction; no new input SHALL be accepted in the cycle out_valid drops (in_ready rises one cycle later).

Reset
REQ-023 While reset = 1, state SHALL be IDLE, in_ready = 1 once reset is released, out_valid = 0, and x_out, y_out, vx_out, vy_out, speed, r and the divider counter SHALL be 0.
REQ-024 Reset asserted in any state, including mid-DIV, SHALL abort the transaction immediately with no output handshake.

Verification
REQ-025 Bypass: x=150<<16, y=150<<16, vx=3<<16, vy=0 -> after 2 cycles out_valid=1, x_out=153<<16, y_out=150<<16, vx_out=3<<16, vy_out=0.
REQ-026 Too fast: same x,y, vx=8<<16, vy=0 -> r=32'h0000_C000, and after 51 cycles vx_out=6<<16, x_out=156<<16, vy_out=0.
REQ-027 Too slow: vx=0, vy=32'hFFFE_0000 (-2.0) -> r=32'h0001_8000, and after 51 cycles vy_out=32'hFFFD_0000 (-3.0), y_out=147<<16.
REQ-028 Zero velocity: vx=vy=0 -> bypass, latency 2, outputs equal x_in, y_in, 0, 0, with no divide.
REQ-029 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 and in_valid ignored; then out_ready=1 -> in_ready=1 on the next cycle.
REQ-030 Reset mid-DIV: assert reset 20 cycles after a too-fast input -> out_valid=0 and all outputs 0 immediately; after release, a bypass transaction completes correctly.
